// File: rtl/ldpc_frame_feeder_if.sv
// Lane-side and decoder-side signal bundle for the LDPC frame feeder.
// The feeder takes the master modport; the noise lanes and decoder core sit on the slave side.
interface ldpc_frame_feeder_if #(
  parameter int unsigned DATA_W = 5,
  parameter int unsigned LANES  = 128,
  parameter int unsigned SPL    = 18
);
  localparam int unsigned DIM = LANES * SPL;

  logic [LANES-1:0]        lane_valid;
  logic [LANES*DATA_W-1:0] lane_llr;
  logic [LANES-1:0]        lane_ce;
  logic [DIM*DATA_W-1:0]   dec_llr;
  logic                    dec_rst;
  logic                    dec_en;
  logic                    dec_term;
  logic [DIM-1:0]          dec_res;

  modport master (
    input  lane_valid, lane_llr, dec_term, dec_res,
    output lane_ce, dec_llr, dec_rst, dec_en
  );

  modport slave (
    output lane_valid, lane_llr, dec_term, dec_res,
    input  lane_ce, dec_llr, dec_rst, dec_en
  );
endinterface

// File: rtl/ldpc_frame_feeder.sv
// LDPC frame feeder: stages LLR samples from independent lanes into a decoder frame, runs the
// decoder with an optional timeout and scores each decoded word against the all-zero codeword.
// Staging refills while the decoder runs, so back-to-back frames are separated by two cycles.
module ldpc_frame_feeder #(
  parameter int unsigned DATA_W = 5,
  parameter int unsigned LANES  = 128,
  parameter int unsigned SPL    = 18,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned TMO_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CNT_W-1:0]    num_frames,
  input  logic [TMO_W-1:0]    max_cyc,
  ldpc_frame_feeder_if.master bus,
  output logic [CNT_W-1:0]    frames,
  output logic [CNT_W-1:0]    bit_errs,
  output logic [CNT_W-1:0]    frame_errs,
  output logic                busy,
  output logic                done
);
  localparam int unsigned DIM   = LANES * SPL;
  localparam int unsigned LaneW = SPL * DATA_W;
  localparam int unsigned LcW   = $clog2(SPL + 1);
  localparam int unsigned PopW  = $clog2(DIM + 1);
  localparam int unsigned SumW  = ((CNT_W > PopW) ? CNT_W : PopW) + 1;

  typedef enum logic [2:0] {StIdle, StFill, StLoad, StDecode, StCheck, StDone} state_e;
  state_e state_q, state_d;

  logic [CNT_W-1:0]      nf_q;
  logic [TMO_W-1:0]      mc_q;
  logic [TMO_W-1:0]      tcnt_q;
  logic                  tmo_q;
  logic [CNT_W-1:0]      frames_q, bit_errs_q, frame_errs_q;
  logic [DIM*DATA_W-1:0] stage_q;
  logic [DIM*DATA_W-1:0] dec_llr_q;
  logic                  dec_rst_q;
  logic [LcW-1:0]        lane_cnt_q [LANES];

  logic [LANES-1:0] lane_ce, lane_full;
  logic             all_full;
  logic             restart;
  logic             term_ok, timeout_hit, last_frame;
  logic [PopW-1:0]  pop;
  logic [SumW-1:0]  bit_sum;

  // Lane fill status and clock enables
  always_comb begin
    lane_full = '0;
    lane_ce   = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_full[i] = (lane_cnt_q[i] == LcW'(SPL));
      lane_ce[i]   = ((state_q == StFill) || (state_q == StDecode)) && !lane_full[i];
    end
    all_full = &lane_full;
  end

  assign restart = start && ((state_q == StIdle) || (state_q == StDone));

  // Per-lane staging shift registers; first sample ends up in the most-significant slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
      for (int i = 0; i < LANES; i++) lane_cnt_q[i] <= '0;
    end else if ((state_q == StLoad) || restart) begin
      for (int i = 0; i < LANES; i++) lane_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (lane_ce[i] && bus.lane_valid[i]) begin
          stage_q[i*LaneW +: LaneW] <= (stage_q[i*LaneW +: LaneW] << DATA_W)
                                       | LaneW'(bus.lane_llr[i*DATA_W +: DATA_W]);
          lane_cnt_q[i] <= lane_cnt_q[i] + LcW'(1);
        end
      end
    end
  end

  // Decoder frame register; dec_rst is registered so it lines up with the new frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_llr_q <= '0;
      dec_rst_q <= 1'b0;
    end else begin
      dec_rst_q <= (state_q == StLoad);
      if (state_q == StLoad) dec_llr_q <= stage_q;
    end
  end

  // Popcount of the hard decisions and the saturating bit-error sum
  always_comb begin
    pop = '0;
    for (int b = 0; b < DIM; b++) pop = pop + PopW'(bus.dec_res[b]);
    bit_sum = SumW'(bit_errs_q) + SumW'(pop);
  end

  // Next-state logic; dec_term is ignored while the decoder is still in its reset cycle
  always_comb begin
    state_d     = state_q;
    term_ok     = bus.dec_term && !dec_rst_q;
    timeout_hit = (mc_q != '0) && ((tcnt_q + TMO_W'(1)) == mc_q);
    last_frame  = (nf_q != '0) && ((frames_q + CNT_W'(1)) == nf_q);
    unique case (state_q)
      StIdle:   if (start) state_d = StFill;
      StFill:   if (all_full) state_d = StLoad;
      StLoad:   state_d = StDecode;
      StDecode: if (term_ok || timeout_hit) state_d = StCheck;
      StCheck: begin
        if (last_frame)    state_d = StDone;
        else if (all_full) state_d = StLoad;
        else               state_d = StFill;
      end
      StDone:   if (start) state_d = StFill;
      default:  state_d = StIdle;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Run configuration, timeout counter and scoring counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nf_q         <= '0;
      mc_q         <= '0;
      tcnt_q       <= '0;
      tmo_q        <= 1'b0;
      frames_q     <= '0;
      bit_errs_q   <= '0;
      frame_errs_q <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            nf_q         <= num_frames;
            mc_q         <= max_cyc;
            tmo_q        <= 1'b0;
            frames_q     <= '0;
            bit_errs_q   <= '0;
            frame_errs_q <= '0;
          end
        end
        StLoad: tcnt_q <= '0;
        StDecode: begin
          tcnt_q <= tcnt_q + TMO_W'(1);
          if (!term_ok && timeout_hit) tmo_q <= 1'b1;
        end
        StCheck: begin
          frames_q <= frames_q + CNT_W'(1);
          if (bit_sum > SumW'({CNT_W{1'b1}})) bit_errs_q <= '1;
          else                                bit_errs_q <= bit_sum[CNT_W-1:0];
          if (((pop != '0) || tmo_q) && (frame_errs_q != '1)) begin
            frame_errs_q <= frame_errs_q + CNT_W'(1);
          end
          tmo_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.lane_ce = lane_ce;
  assign bus.dec_llr = dec_llr_q;
  assign bus.dec_rst = dec_rst_q;
  assign bus.dec_en  = (state_q == StDecode);
  assign frames      = frames_q;
  assign bit_errs    = bit_errs_q;
  assign frame_errs  = frame_errs_q;
  assign busy        = (state_q != StIdle) && (state_q != StDone);
  assign done        = (state_q == StDone);
endmodule

// File: tb/tb_ldpc_frame_feeder.sv
// Scoreboard bench for ldpc_frame_feeder at LANES=4, SPL=3, DATA_W=5, CNT_W=5.
// Stimulus pushes expected frames, decode lengths and run results; a negedge monitor pops them.
module tb_ldpc_frame_feeder;
  localparam int unsigned DW  = 5;
  localparam int unsigned NL  = 4;
  localparam int unsigned SP  = 3;
  localparam int unsigned CW  = 5;
  localparam int unsigned TW  = 8;
  localparam int unsigned DIM = NL * SP;

  typedef struct packed {
    logic [CW-1:0] fr;
    logic [CW-1:0] be;
    logic [CW-1:0] fe;
  } res_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] num_frames = '0;
  logic [TW-1:0] max_cyc = '0;
  logic [CW-1:0] frames, bit_errs, frame_errs;
  logic          busy, done;

  ldpc_frame_feeder_if #(.DATA_W(DW), .LANES(NL), .SPL(SP)) ifc ();

  ldpc_frame_feeder #(
    .DATA_W(DW), .LANES(NL), .SPL(SP), .CNT_W(CW), .TMO_W(TW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_frames (num_frames),
    .max_cyc    (max_cyc),
    .bus        (ifc),
    .frames     (frames),
    .bit_errs   (bit_errs),
    .frame_errs (frame_errs),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nfail = 0;
  int load_cnt = 0;
  int clr_req = 0;
  logic [NL-1:0] lane_en = '1;
  bit term_on = 1'b1;
  int term_dly = 2;

  logic [DIM-1:0]    res_q[$];
  logic [DIM*DW-1:0] llr_q[$];
  int                dlen_q[$];
  res_t              exp_q[$];

  // Sample s of lane i: frame s/SP, slot s%SP; frame k lane i carries k*DIM + i*SP + j + 1
  function automatic logic [DW-1:0] samp(input int i, input int s);
    logic [31:0] v;
    v = 32'(((s / SP) * DIM + i * SP + (s % SP) + 1) & 31);
    return v[DW-1:0];
  endfunction

  function automatic logic [DIM*DW-1:0] frame_llr(input int k);
    logic [DIM*DW-1:0] r;
    r = '0;
    for (int i = 0; i < NL; i++)
      for (int j = 0; j < SP; j++)
        r[i*SP*DW + (SP-1-j)*DW +: DW] = samp(i, k * SP + j);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return ifc.dec_en;
      1:       return ifc.dec_rst;
      default: return done;
    endcase
  endfunction

  // Waits on negedges for a DUT signal to reach a value; an expired budget counts as a failure
  task automatic wait_neg(input int sel, input logic val, input int budget, input string nm);
    bit hit;
    hit = 1'b0;
    for (int n = 0; n < budget && !hit; n++) begin
      @(negedge clk);
      if (sig(sel) == val) hit = 1'b1;
    end
    if (!hit) begin
      nvec++;
      nfail++;
      $display("FAIL %s: timed out after %0d cycles, expected %0b", nm, budget, val);
    end
  endtask

  task automatic do_start(input int nf, input int mc);
    @(posedge clk);
    #2;
    num_frames = CW'(nf);
    max_cyc    = TW'(mc);
    clr_req++;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
  endtask

  task automatic push_frames(input int n, input logic [DIM-1:0] res, input int dlen);
    for (int k = 0; k < n; k++) begin
      llr_q.push_back(frame_llr(k));
      res_q.push_back(res);
      if (dlen > 0) dlen_q.push_back(dlen);
    end
  endtask

  task automatic flush();
    llr_q.delete();
    res_q.delete();
    dlen_q.delete();
    exp_q.delete();
  endtask

  // Lane model: each enabled lane always offers its next sample
  initial begin
    int seq[NL];
    int clr_ack;
    logic [NL-1:0] acc;
    clr_ack = 0;
    for (int i = 0; i < NL; i++) seq[i] = 0;
    ifc.lane_valid = '0;
    ifc.lane_llr   = '0;
    forever begin
      @(negedge clk);
      acc = ifc.lane_valid & ifc.lane_ce;
      @(posedge clk);
      #1;
      if (rst || (clr_req != clr_ack)) begin
        for (int i = 0; i < NL; i++) seq[i] = 0;
        clr_ack = clr_req;
      end else begin
        for (int i = 0; i < NL; i++) if (acc[i]) seq[i]++;
      end
      for (int i = 0; i < NL; i++) begin
        ifc.lane_valid[i]            = lane_en[i];
        ifc.lane_llr[i*DW +: DW]     = samp(i, seq[i]);
      end
    end
  end

  // Decoder model: picks the next hard-decision word at dec_rst, terminates after term_dly
  initial begin
    int dcnt;
    dcnt = 0;
    ifc.dec_term = 1'b0;
    ifc.dec_res  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst || !ifc.dec_en) begin
        dcnt = 0;
        ifc.dec_term = 1'b0;
      end else if (ifc.dec_rst) begin
        dcnt = 0;
        ifc.dec_term = 1'b0;
        ifc.dec_res = (res_q.size() > 0) ? res_q.pop_front() : '0;
      end else begin
        dcnt++;
        ifc.dec_term = term_on && (dcnt >= term_dly);
      end
    end
  end

  // Monitor: loaded frames, decode lengths and end-of-run counters
  initial begin
    bit pe;
    bit pd;
    int dl;
    res_t e;
    pe = 1'b0;
    pd = 1'b0;
    dl = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pe = 1'b0;
        pd = 1'b0;
        dl = 0;
      end else begin
        if (ifc.dec_rst) begin
          load_cnt++;
          if (llr_q.size() > 0) chk("dec_llr", 64'(ifc.dec_llr), 64'(llr_q.pop_front()));
        end
        if (ifc.dec_en) dl++;
        else if (pe) begin
          if (dlen_q.size() > 0) chk("decode_len", 64'(dl), 64'(dlen_q.pop_front()));
          dl = 0;
        end
        if (done && !pd) begin
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("run_frames", 64'(frames), 64'(e.fr));
            chk("run_bit_errs", 64'(bit_errs), 64'(e.be));
            chk("run_frame_errs", 64'(frame_errs), 64'(e.fe));
            chk("run_busy", 64'(busy), 64'd0);
          end else begin
            chk("unexpected_done", 64'(done), 64'd0);
          end
        end
        pe = ifc.dec_en;
        pd = done;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  // Directed stimulus
  initial begin
    int lc0;
    int g;
    bit seen;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_lane_ce", 64'(ifc.lane_ce), 64'd0);
    chk("reset_dec_en", 64'(ifc.dec_en), 64'd0);
    chk("reset_frames", 64'(frames), 64'd0);
    @(posedge clk);
    #3 rst = 1'b0;

    // Run A: decoder never terminates; reset lands mid-DECODE
    term_on = 1'b0;
    push_frames(1, '0, 0);
    do_start(1, 0);
    wait_neg(0, 1'b1, 50, "runA_decode");
    repeat (3) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("abort_dec_en", 64'(ifc.dec_en), 64'd0);
    chk("abort_dec_llr", 64'(ifc.dec_llr), 64'd0);
    chk("abort_dec_rst", 64'(ifc.dec_rst), 64'd0);
    chk("abort_lane_ce", 64'(ifc.lane_ce), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
    flush();
    @(posedge clk);
    #3 rst = 1'b0;

    // Run B: packing, scoring, two-cycle frame gap
    term_on  = 1'b1;
    term_dly = 2;
    llr_q.push_back(frame_llr(0));
    llr_q.push_back(frame_llr(1));
    res_q.push_back(12'b0000_0000_0000);
    res_q.push_back(12'b1000_0010_0001);
    dlen_q.push_back(3);
    dlen_q.push_back(3);
    exp_q.push_back('{fr: CW'(2), be: CW'(3), fe: CW'(1)});
    do_start(2, 0);
    wait_neg(1, 1'b1, 50, "runB_load");
    chk("pack_lane0", 64'(ifc.dec_llr[14:0]), 64'h0443);
    chk("pack_lane3", 64'(ifc.dec_llr[59:45]), 64'h296C);
    wait_neg(0, 1'b0, 50, "runB_check");
    g = 1;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (ifc.dec_en) seen = 1'b1;
      else g++;
    end
    chk("frame_gap", 64'(g), 64'd2);
    wait_neg(2, 1'b1, 100, "runB_done");
    repeat (2) @(negedge clk);
    chk("done_held", 64'(done), 64'd1);

    // Run C: start from DONE clears counters; bit errors saturate
    push_frames(3, 12'hFFF, 3);
    exp_q.push_back('{fr: CW'(3), be: CW'(31), fe: CW'(3)});
    do_start(3, 0);
    @(negedge clk);
    chk("restart_frames", 64'(frames), 64'd0);
    chk("restart_bit_errs", 64'(bit_errs), 64'd0);
    chk("restart_frame_errs", 64'(frame_errs), 64'd0);
    chk("restart_done", 64'(done), 64'd0);
    chk("restart_busy", 64'(busy), 64'd1);
    wait_neg(2, 1'b1, 200, "runC_done");

    // Run D: lane 2 stalls the fill, then the decode times out after 10 cycles
    term_on = 1'b0;
    lane_en = 4'b1011;
    push_frames(1, '0, 10);
    exp_q.push_back('{fr: CW'(1), be: CW'(0), fe: CW'(1)});
    lc0 = load_cnt;
    do_start(1, 10);
    repeat (12) @(negedge clk);
    chk("stall_lane_ce", 64'(ifc.lane_ce), 64'h4);
    chk("stall_no_load", 64'(load_cnt), 64'(lc0));
    chk("stall_busy", 64'(busy), 64'd1);
    lane_en = 4'b1111;
    wait_neg(2, 1'b1, 200, "runD_done");

    // Run E: endless run; frame errors saturate and the frame count wraps
    term_on = 1'b1;
    push_frames(36, 12'hFFF, 0);
    do_start(0, 0);
    for (int n = 0; n < 33; n++) begin
      wait_neg(0, 1'b1, 50, "runE_decode");
      wait_neg(0, 1'b0, 50, "runE_check");
    end
    @(negedge clk);
    chk("sat_frame_errs", 64'(frame_errs), 64'd31);
    chk("sat_bit_errs", 64'(bit_errs), 64'd31);
    chk("wrap_frames", 64'(frames), 64'd1);
    chk("forever_busy", 64'(busy), 64'd1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("final_reset_frame_errs", 64'(frame_errs), 64'd0);
    flush();
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule

// File: doc/ldpc_frame_feeder.md
Name: ldpc_frame_feeder

Overview:
- Parametrised successor to the LDPC noise-to-decoder interface.
- Assembles quantised LLR samples from LANES independent noise/quantiser lanes into a full decoder frame, loads it into the decoder core, and waits for termination or timeout.
- Scores each decoded word against the all-zero transmitted codeword, accumulating bit errors, frame errors and frame count for a run of NUM frames.
- Refill of the staging buffer overlaps decoding.

Parameters:
- DATA_W, 5, LLR sample width (signed).
- LANES, 128, number of sample lanes.
- SPL, 18, samples per lane per frame; DIM = LANES*SPL code bits.
- CNT_W, 32, width of the error and frame counters.
- TMO_W, 16, width of the decode-timeout counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse; begins a run (honoured in IDLE and DONE only)
- num_frames  in  CNT_W  frames per run, sampled at start; 0 = run forever
- max_cyc  in  TMO_W  decode timeout in cycles, sampled at start; 0 = no timeout
- lane_valid  in  LANES  per-lane sample valid
- lane_llr  in  LANES*DATA_W  lane i sample at [i*DATA_W +: DATA_W]
- lane_ce  out  LANES  per-lane clock enable to the noise generator; high = sample accepted when valid
- dec_llr  out  DIM*DATA_W  frame to the decoder, registered
- dec_rst  out  1  one-cycle decoder reset pulse, coincident with the new dec_llr
- dec_en  out  1  decoder enable
- dec_term  in  1  decoder terminated
- dec_res  in  DIM  hard decisions
- frames  out  CNT_W  frames scored this run
- bit_errs  out  CNT_W  total erroneous bits, saturating
- frame_errs  out  CNT_W  frames with errors or timeout, saturating
- busy  out  1  run in progress
- done  out  1  run complete, held

Behaviour:
- Reset: state IDLE. All outputs 0, including dec_llr, dec_rst, dec_en, lane_ce and counters. Staging buffer and lane counts cleared.

Staging buffer:
- Per lane: an SPL*DATA_W shift register plus a count 0..SPL.
- lane_ce[i] = (state in FILL or DECODE) && count[i] < SPL.
- Accept when lane_valid[i] && lane_ce[i]: register shifts left by DATA_W, new sample enters the LSBs, count increments.
- First sample received ends in the most-significant slot.
- Lane i maps to dec_llr[i*SPL*DATA_W +: SPL*DATA_W].
- all_full = all counts == SPL.

States:
- IDLE: on start, latch num_frames and max_cyc, clear counters, go to FILL.
- FILL: go to LOAD when all_full.
- LOAD (1 cycle):
  - dec_llr <= staging; dec_rst = 1; all lane counts cleared; lane_ce = 0, so no sample is accepted this cycle.
  - Go to DECODE.
- DECODE:
  - dec_en = 1 and the timeout counter runs; dec_term is ignored in the first DECODE cycle.
  - If dec_term, go to CHECK.
  - Else if max_cyc != 0 and the counter reaches max_cyc, set tmo and go to CHECK.
  - Lanes keep filling the staging buffer.
- CHECK (1 cycle):
  - dec_en = 0. e = popcount(dec_res), computed from dec_res sampled this cycle.
  - bit_errs += e; frame_errs += (e != 0 || tmo); frames += 1. Error counters saturate at all-ones; frames wraps.
  - Clear tmo.
  - Next state: DONE if num_frames != 0 and frames+1 == num_frames; else LOAD if all_full; else FILL.
- DONE: done = 1, dec_en = 0, counters hold. start clears counters, done and lane counts, relatches inputs, and goes to FILL.

Other rules:
- busy = state not in {IDLE, DONE}.
- start while busy is ignored.
- Frame-to-frame gap is exactly 2 cycles (CHECK, LOAD) when staging is already full.
- Async reset mid-run aborts immediately to reset values; partial frames are discarded.

Test Plan:
- Reset: assert rst mid-DECODE -> all outputs 0 at once, state IDLE, lane_ce = 0; start afterwards begins a clean run.
- Packing (LANES=4, SPL=3, DATA_W=5): lane i supplies samples i*3+1, i*3+2, i*3+3 in order -> at the dec_rst pulse, dec_llr[0 +: 15] = {5'd1, 5'd2, 5'd3}, and lane 3 holds {10, 11, 12} at bits [45 +: 15].
- Scoring: num_frames=2; decoder terminates with dec_res = 12'b0000_0000_0000, then 12'b1000_0010_0001 -> bit_errs = 3, frame_errs = 1, frames = 2, done = 1, busy = 0.
- Timeout: max_cyc=10, dec_term held 0 -> CHECK exactly 10 cycles after entering DECODE; frame_errs += 1 even though dec_res = 0.
- Stall and overlap: lane 2 lane_valid = 0 -> no LOAD while other lanes stop (lane_ce = 0 once full). Lanes full during DECODE -> CHECK goes directly to LOAD (2-cycle gap).
- Saturation and restart: preload frame_errs to the maximum value via a long run -> stays at all-ones. start in DONE -> counters read 0 the next cycle.
